// File: rtl/multibyte_adder_ctrl.sv
// multibyte_adder_ctrl: adds two NUM_BYTES-wide operands one byte per cycle,
// LSB first, through a single shared 8-bit ripple-carry adder.

module adder_nbit #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);
    logic [N:0] c;
    assign c[0] = ci;
    assign co   = c[N];
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
endmodule

module multibyte_adder_ctrl #(
    parameter int NUM_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   start,
    input  logic [8*NUM_BYTES-1:0] a,
    input  logic [8*NUM_BYTES-1:0] b,
    input  logic                   carry_in,
    output logic                   busy,
    output logic                   done,
    output logic [8*NUM_BYTES-1:0] sum,
    output logic                   overflow
);
    localparam int W  = 8 * NUM_BYTES;
    localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          c_q, c_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    add_s;
    logic          add_co;
    logic          last;

    adder_nbit #(.N(8)) u_add (
        .a  (a_q[idx_q*8 +: 8]),
        .b  (b_q[idx_q*8 +: 8]),
        .ci (c_q),
        .s  (add_s),
        .co (add_co)
    );

    assign last = (idx_q == IW'(NUM_BYTES - 1));

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            c_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (start ? ADD : IDLE) :
                  (state_q == ADD)  ? (last ? DONE : ADD) : IDLE;
    end

    // Start is only honoured in IDLE; requests during ADD/DONE are dropped.
    always_comb begin
        idx_d = idx_q;
        c_d   = c_q;
        a_d   = a_q;
        b_d   = b_q;
        sum_d = sum_q;
        ovf_d = ovf_q;
        if (state_q == IDLE && start) begin
            a_d   = a;
            b_d   = b;
            c_d   = carry_in;
            idx_d = '0;
            ovf_d = 1'b0;
        end
        if (state_q == ADD) begin
            sum_d[idx_q*8 +: 8] = add_s;
            c_d                 = add_co;
            if (last) ovf_d = add_co;
            else      idx_d = idx_q + IW'(1);
        end
    end

    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        sum      = sum_q;
        overflow = ovf_q;
    end
endmodule

// File: tb/tb_multibyte_adder_ctrl.sv
// tb_multibyte_adder_ctrl: checks a 4-byte and a 1-byte instance against a
// latency/arithmetic model, plus directed literal cases.

module tb_multibyte_adder_ctrl;
    logic        clk = 1'b0, n_rst = 1'b0;
    logic        s4 = 1'b0, c4 = 1'b0, s1 = 1'b0, c1 = 1'b0;
    logic [31:0] a4 = '0, b4 = '0, sum4;
    logic [7:0]  a1 = '0, b1 = '0, sum1;
    logic        busy4, done4, ovf4, busy1, done1, ovf1;

    int checks = 0, failures = 0;
    bit chk_en = 1'b0;

    // Model: cycles of busy left, pending full-width result, visible result.
    int          left [2] = '{0, 0};
    logic [32:0] res  [2] = '{33'd0, 33'd0};
    logic [31:0] esum [2] = '{32'd0, 32'd0};
    logic        eovf [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    multibyte_adder_ctrl #(.NUM_BYTES(4)) d4 (
        .clk(clk), .n_rst(n_rst), .start(s4), .a(a4), .b(b4), .carry_in(c4),
        .busy(busy4), .done(done4), .sum(sum4), .overflow(ovf4)
    );

    multibyte_adder_ctrl #(.NUM_BYTES(1)) d1 (
        .clk(clk), .n_rst(n_rst), .start(s1), .a(a1), .b(b1), .carry_in(c1),
        .busy(busy1), .done(done1), .sum(sum1), .overflow(ovf1)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int k, input int nb, input logic st,
                        input logic [31:0] aa, input logic [31:0] bb, input logic ci);
        logic [32:0] mask;
        mask = (33'd1 << (8 * nb)) - 33'd1;
        if (!n_rst) begin
            left[k] = 0;
            esum[k] = '0;
            eovf[k] = 1'b0;
        end else if (left[k] > 0) begin
            left[k]--;
            if (left[k] == 1) begin
                esum[k] = 32'(res[k] & mask);
                eovf[k] = res[k][8*nb];
            end
        end else if (st) begin
            res[k]  = ({1'b0, aa} & mask) + ({1'b0, bb} & mask) + {32'd0, ci};
            left[k] = nb + 1;
            eovf[k] = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        step(0, 4, s4, a4, b4, c4);
        step(1, 1, s1, {24'd0, a1}, {24'd0, b1}, c1);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("d4_busy", 64'(busy4), 64'(left[0] > 0));
            check("d4_done", 64'(done4), 64'(left[0] == 1));
            check("d4_ovf", 64'(ovf4), 64'(eovf[0]));
            if (left[0] <= 1) check("d4_sum", 64'(sum4), 64'(esum[0]));
            check("d1_busy", 64'(busy1), 64'(left[1] > 0));
            check("d1_done", 64'(done1), 64'(left[1] == 1));
            check("d1_ovf", 64'(ovf1), 64'(eovf[1]));
            if (left[1] <= 1) check("d1_sum", 64'(sum1), 64'(esum[1][7:0]));
        end
    end

    task automatic go4(input logic [31:0] a, input logic [31:0] b, input logic c);
        s4 = 1'b1; a4 = a; b4 = b; c4 = c;
        @(negedge clk);
        s4 = 1'b0; a4 = $urandom; b4 = $urandom; c4 = 1'($urandom);
    endtask

    task automatic go1(input logic [7:0] a, input logic [7:0] b, input logic c);
        s1 = 1'b1; a1 = a; b1 = b; c1 = c;
        @(negedge clk);
        s1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom);
    endtask

    // Called one cycle after acceptance; returns cycle index of done (bounded).
    task automatic wait_done(input int which, output int k);
        k = 1;
        while (((which == 0) ? done4 : done1) !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        int k, n;
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_sum", 64'(sum4), 64'h0);
        check("rst_ovf", 64'(ovf4), 64'h0);
        check("rst_busy", 64'(busy4), 64'h0);
        check("rst_done", 64'(done4), 64'h0);
        n_rst = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_busy", 64'(busy4), 64'h0);

        go4(32'h000000FF, 32'h00000001, 1'b0);
        wait_done(0, k);
        check("lat4", 64'(k), 64'd5);
        check("carry_sum", 64'(sum4), 64'h00000100);
        check("carry_ovf", 64'(ovf4), 64'h0);
        @(negedge clk);

        go4(32'hFFFFFFFF, 32'h00000000, 1'b1);
        wait_done(0, k);
        check("ripple_sum", 64'(sum4), 64'h0);
        check("ripple_ovf", 64'(ovf4), 64'h1);
        @(negedge clk);

        go4(32'h12345678, 32'h11111111, 1'b0);
        s4 = 1'b1; a4 = 32'hFFFFFFFF; b4 = 32'hFFFFFFFF;
        wait_done(0, k);
        check("busy_sum", 64'(sum4), 64'h23456789);
        check("busy_ovf", 64'(ovf4), 64'h0);
        @(negedge clk);
        s4 = 1'b0;
        check("busy_ignored", 64'(busy4), 64'h0);
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (done4) n++;
        end
        check("busy_extra_done", 64'(n), 64'h0);

        go4(32'h80000000, 32'h80000000, 1'b0);
        @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        check("midrst_sum", 64'(sum4), 64'h0);
        check("midrst_ovf", 64'(ovf4), 64'h0);
        check("midrst_busy", 64'(busy4), 64'h0);
        n = 0;
        repeat (7) begin
            @(negedge clk);
            if (done4) n++;
        end
        check("midrst_nodone", 64'(n), 64'h0);
        go4(32'd1, 32'd2, 1'b0);
        wait_done(0, k);
        check("after_rst_sum", 64'(sum4), 64'd3);
        @(negedge clk);

        go4(32'hDEADBEEF, 32'h01010101, 1'b1);
        wait_done(0, k);
        @(negedge clk);
        go4(32'hCAFEF00D, 32'h35010FF2, 1'b1);
        wait_done(0, k);
        check("b2b_spacing", 64'(k + 1), 64'd6);
        check("b2b_sum", 64'(sum4), 64'h0);
        check("b2b_ovf", 64'(ovf4), 64'h1);
        @(negedge clk);

        go1(8'hF0, 8'h20, 1'b0);
        wait_done(1, k);
        check("lat1", 64'(k), 64'd2);
        check("nb1_sum", 64'(sum1), 64'h10);
        check("nb1_ovf", 64'(ovf1), 64'h1);
        @(negedge clk);

        repeat (600) begin
            n_rst = ($urandom_range(0, 79) != 0);
            s4 = 1'($urandom); s1 = 1'($urandom);
            c4 = 1'($urandom); c1 = 1'($urandom);
            a4 = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
            b4 = $urandom;
            a1 = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            b1 = 8'($urandom);
            @(negedge clk);
        end
        n_rst = 1'b1; s4 = 1'b0; s1 = 1'b0;
        repeat (20) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
